// File: rtl/dstack_ring.sv
// Ring-buffer data stack: top held in a register, deeper entries in a circular
// array indexed by sp, with saturating depth, fault pulses and a sequenced rotate.
module dstack_ring #(
  parameter int WIDTH     = 32,
  parameter int DEPTH_MAG = 7,
  parameter int ROT_MAG   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [1:0]           movement,
  input  logic                 rotate,
  input  logic [ROT_MAG-1:0]   rot_addr,
  input  logic [WIDTH-1:0]     new_top,
  output logic [WIDTH-1:0]     top,
  output logic [WIDTH-1:0]     second,
  output logic [WIDTH-1:0]     rot_val,
  output logic [DEPTH_MAG:0]   depth,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH = 1 << DEPTH_MAG;
  localparam logic S_IDLE = 1'b0;
  localparam logic S_ROT  = 1'b1;

  localparam logic [DEPTH_MAG-1:0] SP_ONE = DEPTH_MAG'(1);
  localparam logic [DEPTH_MAG-1:0] SP_TWO = DEPTH_MAG'(2);
  localparam logic [DEPTH_MAG:0]   D_ONE  = (DEPTH_MAG+1)'(1);
  localparam logic [DEPTH_MAG:0]   D_TWO  = (DEPTH_MAG+1)'(2);
  localparam logic [DEPTH_MAG:0]   D_FULL = (DEPTH_MAG+1)'(DEPTH);
  localparam logic [ROT_MAG-1:0]   C_ONE  = ROT_MAG'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_MAG-1:0] sp;
  logic                 state;
  logic [ROT_MAG-1:0]   cnt;
  logic [WIDTH-1:0]     hold;

  logic                 accept;
  logic [DEPTH_MAG-1:0] rot_off;
  logic [DEPTH_MAG-1:0] cnt_off;
  logic                 we;
  logic [DEPTH_MAG-1:0] waddr;
  logic [WIDTH-1:0]     wdata;

  assign op_ready = (state == S_IDLE);
  assign accept   = op_valid & op_ready;
  // Offsets are taken modulo DEPTH, matching the ring addressing.
  assign rot_off  = DEPTH_MAG'(rot_addr);
  assign cnt_off  = DEPTH_MAG'(cnt);
  assign second   = mem[sp];
  assign rot_val  = mem[sp - rot_off];

  // Single array write port: push, rotate start, or one rotate step.
  always_comb begin
    we    = 1'b0;
    waddr = sp;
    wdata = top;
    if (!reset) begin
      if (accept) begin
        if (rotate) begin
          we = 1'b1;
          if (rot_addr == '0) begin
            waddr = sp;
            wdata = top;
          end else begin
            waddr = sp - rot_off;
            wdata = mem[sp - rot_off + SP_ONE];
          end
        end else if (movement == 2'b01) begin
          we    = 1'b1;
          waddr = sp + SP_ONE;
          wdata = top;
        end
      end else if (state == S_ROT) begin
        we    = 1'b1;
        waddr = sp - cnt_off;
        wdata = (cnt == '0) ? hold : mem[sp - cnt_off + SP_ONE];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (accept && rotate) hold <= top;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top       <= '0;
      sp        <= '0;
      depth     <= '0;
      state     <= S_IDLE;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (accept) begin
        top <= new_top;
        if (rotate) begin
          if (32'(rot_addr) + 32'd1 > 32'(depth)) underflow <= 1'b1;
          if (rot_addr != '0) begin
            cnt   <= rot_addr - C_ONE;
            state <= S_ROT;
          end
        end else begin
          case (movement)
            2'b01: begin
              sp <= sp + SP_ONE;
              if (depth == D_FULL) overflow <= 1'b1;
              else                 depth    <= depth + D_ONE;
            end
            2'b10: begin
              if (depth == '0) begin
                underflow <= 1'b1;
              end else begin
                sp    <= sp - SP_ONE;
                depth <= depth - D_ONE;
              end
            end
            2'b11: begin
              if (depth < D_TWO) begin
                underflow <= 1'b1;
                sp        <= sp - DEPTH_MAG'(depth);
                depth     <= '0;
              end else begin
                sp    <= sp - SP_TWO;
                depth <= depth - D_TWO;
              end
            end
            default: ;
          endcase
        end
      end else if (state == S_ROT) begin
        if (cnt == '0) state <= S_IDLE;
        else           cnt   <= cnt - C_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dstack_ring.sv
// Scoreboard bench for dstack_ring using a position-list reference model.
module tb_dstack_ring;

  localparam int W  = 16;
  localparam int DM = 2;
  localparam int RM = 2;
  localparam int D  = 1 << DM;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [1:0]    movement = 2'b00;
  logic          rotate = 1'b0;
  logic [RM-1:0] rot_addr = '0;
  logic [W-1:0]  new_top = '0;
  logic [W-1:0]  top, second, rot_val;
  logic [DM:0]   depth;
  logic          overflow, underflow;

  dstack_ring #(.WIDTH(W), .DEPTH_MAG(DM), .ROT_MAG(RM)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .movement(movement), .rotate(rotate), .rot_addr(rot_addr), .new_top(new_top),
    .top(top), .second(second), .rot_val(rot_val), .depth(depth),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] top;
    int           depth;
    bit           ovf;
    bit           unf;
    bit           rdy;
    logic [W-1:0] sec;
    bit           secv;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model: m_r[i] holds position i+1.
  logic [W-1:0] m_top;
  logic [W-1:0] m_r [D];
  int           m_depth;
  int           m_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic rot_up(input int k);
    logic [W-1:0] t [D];
    for (int i = 0; i < D; i++) t[i] = m_r[i];
    for (int i = 0; i < D; i++) m_r[i] = t[(i + k) % D];
  endtask

  task automatic cycle(input bit rst, input bit valid, input logic [1:0] mov,
                       input bit rot, input int n, input logic [W-1:0] nt);
    exp_t e;
    bit acc;
    logic [W-1:0] old_top;
    logic [W-1:0] t [D];
    @(negedge clk);
    reset    = rst;
    op_valid = valid;
    movement = mov;
    rotate   = rot;
    rot_addr = RM'(n);
    new_top  = nt;
    if (!rst && m_busy == 0 && n < m_depth) begin
      #1;
      check("rot_val", rot_val, m_r[n]);
    end
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (rst) begin
      m_top = '0; m_depth = 0; m_busy = 0;
      for (int i = 0; i < D; i++) m_r[i] = 'x;
    end else begin
      acc = valid && (m_busy == 0);
      if (acc) begin
        old_top = m_top;
        m_top   = nt;
        if (rot) begin
          e.unf = (n + 1 > m_depth);
          for (int i = 0; i < D; i++) t[i] = m_r[i];
          m_r[0] = old_top;
          for (int k = 1; k <= n; k++) m_r[k] = t[k-1];
          m_busy = n;
        end else begin
          case (mov)
            2'b01: begin
              e.ovf = (m_depth == D);
              for (int k = D - 1; k >= 1; k--) m_r[k] = m_r[k-1];
              m_r[0] = old_top;
              if (m_depth < D) m_depth++;
            end
            2'b10: begin
              if (m_depth == 0) e.unf = 1'b1;
              else begin rot_up(1); m_depth--; end
            end
            2'b11: begin
              if (m_depth < 2) begin e.unf = 1'b1; rot_up(m_depth); m_depth = 0; end
              else begin rot_up(2); m_depth -= 2; end
            end
            default: ;
          endcase
        end
      end else if (m_busy > 0) begin
        m_busy--;
      end
    end
    e.top   = m_top;
    e.depth = m_depth;
    e.rdy   = (m_busy == 0);
    e.sec   = m_r[0];
    e.secv  = (m_busy == 0) && (m_depth >= 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("top", top, e.top);
    check("depth", depth, e.depth);
    check("overflow", overflow, e.ovf);
    check("underflow", underflow, e.unf);
    check("op_ready", op_ready, e.rdy);
    if (e.secv) check("second", second, e.sec);
  endtask

  task automatic idle(input int n);
    cycle(0, 0, 2'b00, 0, n, '0);
  endtask

  initial begin
    m_top = '0; m_depth = 0; m_busy = 0;
    // Fill to capacity, then overflow once.
    cycle(1, 0, 2'b00, 0, 0, '0);
    cycle(0, 1, 2'b00, 0, 0, 16'd1);
    for (int v = 2; v <= 5; v++) cycle(0, 1, 2'b01, 0, 0, W'(v));
    cycle(0, 1, 2'b01, 0, 0, 16'd6);
    for (int k = 0; k < D; k++) idle(k);
    // Pop, then double pops down to underflow.
    cycle(0, 1, 2'b10, 0, 0, 16'd7);
    cycle(0, 1, 2'b11, 0, 0, 16'd8);
    cycle(0, 1, 2'b11, 0, 0, 16'd9);
    idle(0);
    // Swap on an empty array underflows.
    cycle(1, 0, 2'b00, 0, 0, '0);
    cycle(0, 1, 2'b00, 1, 0, 16'h0055);
    // Build top=A, B, C, D and rotate by 1.
    cycle(1, 0, 2'b00, 0, 0, '0);
    cycle(0, 1, 2'b00, 0, 0, 16'h000D);
    cycle(0, 1, 2'b01, 0, 0, 16'h000C);
    cycle(0, 1, 2'b01, 0, 0, 16'h000B);
    cycle(0, 1, 2'b01, 0, 0, 16'h000A);
    cycle(0, 1, 2'b00, 1, 1, m_r[1]);
    idle(0);
    for (int k = 0; k < 3; k++) idle(k);
    // Swap.
    cycle(0, 1, 2'b00, 1, 0, m_r[0]);
    idle(1);
    // Rotate by 3 at full depth with ops held during busy.
    cycle(0, 1, 2'b01, 0, 0, 16'h000E);
    cycle(0, 1, 2'b00, 1, 3, m_r[3]);
    for (int k = 0; k < 3; k++) cycle(0, 1, 2'b01, 0, 0, 16'h0099);
    cycle(0, 1, 2'b00, 0, 0, 16'h0077);
    for (int k = 0; k < D; k++) idle(k);
    // Reset aborts a rotate in its second cycle.
    cycle(0, 1, 2'b00, 1, 3, m_r[3]);
    cycle(1, 1, 2'b01, 0, 0, 16'h0042);
    idle(0);
    idle(0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dstack_ring.md
Name: dstack_ring

Overview:
Parametrised successor to the core0 data stack. The top-of-stack lives in a register. All deeper entries live in a circular register array addressed by a stack pointer, so push and pop no longer shift every element.
Adds a saturating depth count, an underflow fault, and a multi-cycle rotate sequenced by an FSM with a ready handshake. Sits in the core0 execute stage in place of the shift-register stack.

Parameters:
WIDTH, 32, word width
DEPTH_MAG, 7, log2 of array entries below top (DEPTH = 1 << DEPTH_MAG)
ROT_MAG, 6, width of rotate address (max rotate depth 2^ROT_MAG - 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  operation presented this cycle
op_ready  out  1  block can accept an operation; low while a rotate is in progress
movement  in  2  00 none, 01 push, 10 pop, 11 double pop
rotate  in  1  rotate request; takes precedence, movement ignored
rot_addr  in  ROT_MAG  rotate/pick depth n
new_top  in  WIDTH  value written to top on accept
top  out  WIDTH  position 0
second  out  WIDTH  position 1 = mem[sp]
rot_val  out  WIDTH  position n+1 = mem[sp - rot_addr], combinational
depth  out  DEPTH_MAG+1  valid entries in array (0..DEPTH)
overflow  out  1  one-cycle registered pulse: push while full
underflow  out  1  one-cycle registered pulse: pop or rotate past depth

Behaviour:
- Reset (synchronous, high):
  - top=0, sp=0, depth=0, state=IDLE, op_ready=1, overflow=0, underflow=0.
  - Array contents are not cleared.
  - Reset during ROT aborts the rotate immediately; a partially shifted array is acceptable.
- Position p>=1 is stored at mem[sp-(p-1)]. All pointer arithmetic is modulo DEPTH.
- Accept means op_valid & op_ready. A non-accepted cycle changes nothing except continuing an in-progress rotate.
- Any accepted op sets top <= new_top, including movement 00 (replace top).
- Push (01):
  - sp <= sp+1; mem[sp+1] <= old top.
  - depth <= min(depth+1, DEPTH).
  - If depth==DEPTH: overflow=1 next cycle, and the oldest entry is overwritten.
- Pop (10):
  - sp <= sp-1; depth <= depth-1.
  - If depth==0: underflow=1, sp and depth unchanged.
- Double pop (11):
  - sp <= sp-2; depth <= depth-2.
  - If depth<2: underflow=1, depth <= 0, sp <= sp-depth.
- Rotate by n:
  - Host drives new_top = rot_val in the same cycle.
  - Result: top = old pos n+1, pos1 = old top, pos k+1 = old pos k for 1<=k<=n. Deeper entries and depth are unchanged.
  - If n+1 > depth: underflow pulses, and the rotate is still executed.
- Rotate FSM (IDLE, ROT):
  - n==0: single cycle, mem[sp] <= old top, stay IDLE (swap).
  - n>0, accept cycle: write pos n+1 <= pos n, latch old top into a hold register, load counter=n-1, go to ROT, op_ready <= 0.
  - In ROT, each cycle with counter c>0: pos c+1 <= pos c, c <= c-1.
  - c==0: pos1 <= held top, go to IDLE, op_ready <= 1 next cycle.
  - Total: n+1 writes; op_ready is low for exactly n cycles.
- During ROT:
  - top is valid from the cycle after accept.
  - second and rot_val are undefined until return to IDLE.
- The array has one write port per cycle; no op both pushes and rotates.
- overflow and underflow are registered and never asserted together.

Test Plan:
- DEPTH_MAG=2. After reset, push new_top=1,2,3,4,5 -> top=5, second=4, depth=4, no overflow; push 6 -> overflow pulses 1 cycle, depth=4, positions 1..4 = 5,4,3,2.
- From top=5, depth=4: pop -> top=new_top, second=3, depth=3; double pop twice -> second pop gives underflow=1, depth=0.
- top=A, pos1..3=B,C,D: rotate n=1, new_top=rot_val=C -> op_ready low 1 cycle; then top=C, pos1=A, pos2=B, pos3=D, depth unchanged.
- Rotate n=0 with top=A, second=B, new_top=B -> top=B, second=A, op_ready never drops.
- Rotate n=3 with depth=4 and op_valid held high during busy -> op_ready low 3 cycles, held ops not accepted; first op after return is accepted.
- Reset asserted in the 2nd cycle of rotate n=3 -> next cycle depth=0, op_ready=1, top=0, no fault pulses.
